ysyx_22040750_csr_regfile: RTL

YSYX_22040750_CSR_REGFILE -- requirements
Module: ysyx_22040750_csr_regfile

---
 rtl/ysyx_22040750_csr_regfile.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ysyx_22040750_csr_regfile.sv
// Machine-mode CSR file: eight CSRs, ecall/mret/timer-interrupt trap handling
// and the pipeline redirect that goes with them.
module ysyx_22040750_csr_regfile (
  input  logic        I_sys_clk,
  input  logic        I_rst,
  input  logic        I_valid,
  input  logic [63:0] I_pc,
  input  logic [11:0] I_csr_addr,
  input  logic        I_csr_wen,
  input  logic [63:0] I_csr_wdata,
  input  logic        I_ecall,
  input  logic        I_mret,
  input  logic        I_timer_irq,
  output logic [63:0] O_csr_rdata,
  output logic        O_csr_illegal,
  output logic        O_trap_valid,
  output logic [63:0] O_trap_pc
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;

  localparam logic [63:0] CAUSE_MTI   = 64'h8000_0000_0000_0007;
  localparam logic [63:0] CAUSE_ECALL = 64'd11;

  // Only MIE/MPIE of mstatus are stored; MPP reads as constant 2'b11.
  logic        st_mie_q, st_mie_d;
  logic        st_mpie_q, st_mpie_d;
  logic [63:0] mie_q, mie_d;
  logic [63:0] mtvec_q, mtvec_d;
  logic [63:0] mscratch_q, mscratch_d;
  logic [63:0] mepc_q, mepc_d;
  logic [63:0] mcause_q, mcause_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic        mtip_q, mtip_d;

  logic [63:0] mstatus_rd;
  logic        irq_take;
  logic        ecall_take;
  logic        mret_take;
  logic        trap_take;
  logic        csr_we;

  assign mstatus_rd = {51'b0, 2'b11, 3'b0, st_mpie_q, 3'b0, st_mie_q, 3'b0};

  always_comb begin
    O_csr_rdata   = 64'b0;
    O_csr_illegal = 1'b0;
    case (I_csr_addr)
      ADDR_MSTATUS:  O_csr_rdata = mstatus_rd;
      ADDR_MIE:      O_csr_rdata = mie_q;
      ADDR_MTVEC:    O_csr_rdata = mtvec_q;
      ADDR_MSCRATCH: O_csr_rdata = mscratch_q;
      ADDR_MEPC:     O_csr_rdata = {mepc_q[63:2], 2'b00};
      ADDR_MCAUSE:   O_csr_rdata = mcause_q;
      ADDR_MIP:      O_csr_rdata = {56'b0, mtip_q, 7'b0};
      ADDR_MCYCLE:   O_csr_rdata = mcycle_q;
      default:       O_csr_illegal = 1'b1;
    endcase
  end

  // Priority: interrupt > ecall > mret > CSR write.
  assign irq_take   = I_valid & st_mie_q & mie_q[7] & mtip_q;
  assign ecall_take = I_valid & I_ecall & ~irq_take;
  assign mret_take  = I_valid & I_mret & ~I_ecall & ~irq_take;
  assign trap_take  = irq_take | ecall_take | mret_take;
  assign csr_we     = I_valid & I_csr_wen & ~O_csr_illegal & ~trap_take;

  always_comb begin
    O_trap_valid = trap_take & ~I_rst;
    O_trap_pc    = 64'b0;
    if (O_trap_valid) begin
      O_trap_pc = mret_take ? {mepc_q[63:2], 2'b00} : {mtvec_q[63:2], 2'b00};
    end
  end

  always_comb begin
    st_mie_d   = st_mie_q;
    st_mpie_d  = st_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mcycle_d   = mcycle_q + 64'd1;
    mtip_d     = I_timer_irq;
    if (irq_take || ecall_take) begin
      mepc_d    = I_pc;
      mcause_d  = irq_take ? CAUSE_MTI : CAUSE_ECALL;
      st_mpie_d = st_mie_q;
      st_mie_d  = 1'b0;
    end else if (mret_take) begin
      st_mie_d  = st_mpie_q;
      st_mpie_d = 1'b1;
    end else if (csr_we) begin
      case (I_csr_addr)
        ADDR_MSTATUS: begin
          st_mie_d  = I_csr_wdata[3];
          st_mpie_d = I_csr_wdata[7];
        end
        ADDR_MIE:      mie_d      = I_csr_wdata;
        ADDR_MTVEC:    mtvec_d    = I_csr_wdata;
        ADDR_MSCRATCH: mscratch_d = I_csr_wdata;
        ADDR_MEPC:     mepc_d     = I_csr_wdata;
        ADDR_MCAUSE:   mcause_d   = I_csr_wdata;
        ADDR_MCYCLE:   mcycle_d   = I_csr_wdata;
        default:       ;
      endcase
    end
  end

  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      st_mie_q   <= 1'b0;
      st_mpie_q  <= 1'b0;
      mie_q      <= 64'b0;
      mtvec_q    <= 64'b0;
      mscratch_q <= 64'b0;
      mepc_q     <= 64'b0;
      mcause_q   <= 64'b0;
      mcycle_q   <= 64'b0;
      mtip_q     <= 1'b0;
    end else begin
      st_mie_q   <= st_mie_d;
      st_mpie_q  <= st_mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      mtip_q     <= mtip_d;
    end
  end

endmodule
